noise_checker: RTL

//  Receive-side checker for the LFSR noise generator (x^16+x^14+x^13+x^11 taps, scaled output).

---
 rtl/noise_checker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/noise_checker.sv
// noise_checker: rebuilds the LFSR bit stream from scaled noise words, locks to it, then counts samples that break the recurrence or shift continuity.
// Latency: every output is registered and reflects the accepted sample one cycle later.
// Backpressure: none; each data_valid sample is consumed in the cycle it arrives.
module noise_checker #(
  parameter int CNT_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       noise_level,
  input  logic [15:0]      data_in,
  input  logic             data_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [7:0]       loss_count,
  output logic [1:0]       state_out
);

  localparam int BW = $clog2(LOSS_THRESH + 1);
  localparam logic [BW-1:0]    BAD_ONE   = BW'(1);
  localparam logic [BW-1:0]    LOSS_LAST = BW'(LOSS_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t        state;
  logic [15:0]   hist;       // recovered LFSR bits, hist[0] newest
  logic [14:0]   prev_word;  // previous accepted word; bit 15 is always zero
  logic [3:0]    fill_cnt;   // consecutive good samples gathered in FILL
  logic [BW-1:0] bad_cnt;    // consecutive bad samples while LOCKED
  logic [1:0]    level_q;

  logic        active, accept, level_chg, in_lock;
  logic        new_bit, exp_bit, cont_ok, bad;
  logic [15:0] keep_mask, hist_b;
  logic        inc_err, inc_smp, inc_loss;

  assign state_out = state;

  // Sample qualification, continuity test and recurrence prediction.
  always_comb begin
    active    = enable && (noise_level != 2'b00);
    accept    = active && data_valid;
    level_chg = active && (noise_level != level_q);
    // Bits 1..14-k must be the previous word shifted up by one; bits above must be zero.
    case (noise_level)
      2'b01:   keep_mask = 16'h0FFE;
      2'b10:   keep_mask = 16'h1FFE;
      default: keep_mask = 16'h3FFE;
    endcase
    new_bit  = data_in[0];
    exp_bit  = hist[15] ^ hist[13] ^ hist[12] ^ hist[10];
    hist_b   = {hist[14:0], new_bit};
    cont_ok  = ({data_in[15:1], 1'b0} == ({prev_word, 1'b0} & keep_mask));
    bad      = (new_bit != exp_bit) || !cont_ok;
    in_lock  = accept && !level_chg && (state == LOCKED);
    inc_smp  = in_lock;
    inc_err  = in_lock && bad;
    inc_loss = inc_err && (bad_cnt == LOSS_LAST);
  end

  // Lock FSM: gather 16 continuous samples, then flywheel through isolated errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      hist      <= '0;
      prev_word <= '0;
      fill_cnt  <= '0;
      bad_cnt   <= '0;
      level_q   <= '0;
    end else begin
      level_q   <= noise_level;
      err_pulse <= 1'b0;
      if (!active) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else if (state == IDLE || level_chg) begin
        // A sample arriving with the (re)start is the first, unchecked fill sample.
        state    <= FILL;
        locked   <= 1'b0;
        bad_cnt  <= '0;
        fill_cnt <= '0;
        if (accept) begin
          hist      <= hist_b;
          prev_word <= data_in[14:0];
          fill_cnt  <= 4'd1;
        end
      end else if (accept) begin
        prev_word <= data_in[14:0];
        if (state == FILL) begin
          hist <= hist_b;
          if (fill_cnt != 4'd0 && !cont_ok) begin
            fill_cnt <= 4'd1;
          end else if (fill_cnt == 4'd15) begin
            fill_cnt <= '0;
            // The all-zero register is a dead state of the LFSR; never lock to it.
            if (hist_b != 16'h0000) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              bad_cnt <= '0;
            end
          end else begin
            fill_cnt <= fill_cnt + 4'd1;
          end
        end else begin
          if (bad) begin
            err_pulse <= 1'b1;
            hist      <= {hist[14:0], exp_bit};
            if (bad_cnt == LOSS_LAST) begin
              state    <= FILL;
              locked   <= 1'b0;
              fill_cnt <= '0;
              bad_cnt  <= '0;
            end else begin
              bad_cnt <= bad_cnt + BAD_ONE;
            end
          end else begin
            bad_cnt <= '0;
            hist    <= hist_b;
          end
        end
      end
    end
  end

  // Saturating statistics counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count    <= '0;
      sample_count <= '0;
      loss_count   <= '0;
    end else if (clear_counts) begin
      err_count    <= '0;
      sample_count <= '0;
      loss_count   <= '0;
    end else begin
      if (inc_err && err_count != '1)      err_count    <= err_count + CNT_ONE;
      if (inc_smp && sample_count != '1)   sample_count <= sample_count + CNT_ONE;
      if (inc_loss && loss_count != 8'hFF) loss_count   <= loss_count + 8'd1;
    end
  end

endmodule
